simmem_resp_checker: RTL
========================

# simmem_resp_checker

Receive-side checker for the simulated memory controller's linked-list response bank. It acts as the consumer on the bank's output valid/ready port, optionally applying pseudo-random backpressure. It checks that responses of each ID arrive in order with the expected values, and reports completion, pass/fail and a received-beat count to the surrounding bench top.

## Interface
Parameters:
- StructWidth, 32: width of a response word. Bits [IDWidth-1:0] carry the ID.
- IDWidth, 2: ID field width; number of IDs is 2**IDWidth.
- NbExpected, 26: number of responses that completes the test.
- TimeoutCycles, 1000: maximum idle cycles in RUN between accepted beats.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- start_i  in  1  leaves IDLE and begins checking.
- data_i  in  StructWidth  response word from the bank.
- in_valid_i  in  1  response valid.
- in_ready_o  out  1  checker ready.
- done_o  out  1  test finished (DONE or FAIL).
- passed_o  out  1  test passed (DONE only).
- nb_received_o  out  32  accepted-beat count.

## Operation
- State machine states: IDLE, RUN, DONE, FAIL.
  - IDLE → RUN: on start_i.
  - RUN → FAIL: on a mismatch, or when the timeout counter reaches TimeoutCycles.
  - RUN → DONE: when a matching handshake brings the count to NbExpected.
  - DONE → FAIL: on any handshake while in DONE (extra response).
  - FAIL: terminal until reset.
- start_i is ignored outside IDLE.
- Handshake occurs when in_valid_i and in_ready_o are both high.
- Per-ID expected register exp[i], StructWidth wide:
  - Reset value is i, zero-extended.
  - On each accepted beat with id = data_i[IDWidth-1:0]:
    - Mismatch if data_i != exp[id].
    - Otherwise exp[id] += 2**IDWidth, wrapping modulo 2**StructWidth.
- Ordering across different IDs is unconstrained. Ordering within one ID is strict.
- nb_received_o increments on every handshake, including a mismatching or extra one. It saturates at 2**32-1.
- Timeout counter (32 bit):
  - Counts cycles in RUN since the last handshake.
  - Cleared on a handshake and on entry to RUN.
- in_ready_o:
  - IDLE and FAIL: 0.
  - DONE: 1, to drain extra responses.
  - RUN: 1, or the LFSR pattern when backpressure is enabled.
- done_o = (state==DONE) | (state==FAIL).
- passed_o = (state==DONE).

## Timing
- Reset values: in_ready_o=0, done_o=0, passed_o=0, nb_received_o=0, state=IDLE, exp[i]=i, LFSR=16'hACE1.
- in_ready_o is a function of registered state only. There is no combinational path from in_valid_i or data_i.
- The check is evaluated combinationally in the handshake cycle. State, counters and exp update at the next rising edge.
- done_o/passed_o rise one cycle after the final handshake.
- Boundary conditions:
  - Mismatch on the NbExpected-th beat: go to FAIL, not DONE.
  - Handshake in the same cycle the timeout counter would reach TimeoutCycles: the handshake wins and the counter clears.
  - in_valid_i held with in_ready_o low: no state change. The timeout counter still runs.
  - Reset asserted mid-test: all state returns to reset values asynchronously. in_ready_o drops immediately.
  - NbExpected = 0: RUN → DONE on the first cycle in RUN.

## Configuration
- SIMMEM_RESP_CHECKER_BACKPRESSURE_EN defined:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 advances every cycle in RUN.
  - In RUN, in_ready_o = lfsr[0] | lfsr[1], giving about 75% duty.
- Macro undefined:
  - No LFSR is instantiated.
  - In RUN, in_ready_o = 1 constantly.

## Structure
- Package simmem_resp_checker_pkg holds:
  - the state enum type;
  - the LFSR seed and tap-mask constants;
  - the default timeout constant.
- Sub-module simmem_lfsr16: 16-bit LFSR with enable, instantiated only under the macro.
- The per-ID expected registers, the timeout counter and the state machine remain in the top module.

## Test plan
- Nominal run: start_i pulse, then 26 words 0..25 offered back-to-back in order, macro off.
  - Required: in_ready_o is 1 throughout RUN.
  - Required: passed_o=1 and nb_received_o=26, one cycle after the last beat.
- Cross-ID reordering: send 1,0,3,2,5,4,... up to 25.
  - Required: pass. Per-ID order is preserved; cross-ID reordering is allowed.
- Same-ID reordering: send 0,1,2,3,8,4.
  - Required: at beat 8 (ID 0, expected 4), FAIL with done_o=1 and passed_o=0.
  - Required: nb_received_o=5.
- Timeout: start, send 3 correct words, then hold in_valid_i low.
  - Required: FAIL exactly 1000 cycles after the third handshake.
- Extra beat: after DONE is reached, offer word 26.
  - Required: handshake accepted, passed_o falls to 0, nb_received_o=27.
- Backpressure (macro on):
  - Required: in_ready_o follows the LFSR sequence from seed ACE1.
  - Required: nominal data still passes.
  - Required: reset asserted mid-stream clears nb_received_o and in_ready_o, and a restarted run passes.

Source files
------------

// File: rtl/simmem_resp_checker_pkg.sv
// Shared types and constants for the simulated-memory response checker.
// Feature macro: SIMMEM_RESP_CHECKER_BACKPRESSURE_EN (backpressure LFSR).
package simmem_resp_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StFail
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LfsrTapMask = 16'h002D;

  localparam int unsigned DefaultTimeout = 1000;

endpackage

// File: rtl/simmem_lfsr16.sv
// 16-bit right-shifting Fibonacci LFSR with enable, used to pace backpressure.
module simmem_lfsr16 #(
  parameter logic [15:0] Seed    = 16'hACE1,
  parameter logic [15:0] TapMask = 16'h002D
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] r_lfsr_q;
  logic        w_fb;

  assign w_fb = ^(r_lfsr_q & TapMask);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr_q <= Seed;
    end else if (en_i) begin
      r_lfsr_q <= {w_fb, r_lfsr_q[15:1]};
    end
  end

  assign state_o = r_lfsr_q;

endmodule

// File: rtl/simmem_resp_checker.sv
// Consumer/checker for the linked-list response bank: per-ID in-order value check.
// Define SIMMEM_RESP_CHECKER_BACKPRESSURE_EN for LFSR-paced ready in RUN.
module simmem_resp_checker
  import simmem_resp_checker_pkg::*;
#(
  parameter int unsigned StructWidth   = 32,
  parameter int unsigned IDWidth       = 2,
  parameter int unsigned NbExpected    = 26,
  parameter int unsigned TimeoutCycles = DefaultTimeout
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [StructWidth-1:0] data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   done_o,
  output logic                   passed_o,
  output logic [31:0]            nb_received_o
);

  localparam int unsigned NbIds = 2 ** IDWidth;

  state_e                 r_state_q, w_state_d;
  logic [StructWidth-1:0] r_exp_q [NbIds];
  logic [31:0]            r_nb_q, w_nb_d;
  logic [31:0]            r_timeout_q, w_timeout_d;

  logic [IDWidth-1:0] w_id;
  logic               w_hs;
  logic               w_match;
  logic [31:0]        w_nb_inc;
  logic [31:0]        w_timeout_inc;
  logic               w_final;
  logic               w_timeout_hit;
  logic               w_run_ready;

  assign w_id          = data_i[IDWidth-1:0];
  assign w_hs          = in_valid_i & in_ready_o;
  assign w_match       = (data_i == r_exp_q[w_id]);
  assign w_nb_inc      = (r_nb_q == '1) ? r_nb_q : r_nb_q + 32'd1;
  assign w_timeout_inc = (r_timeout_q == '1) ? r_timeout_q : r_timeout_q + 32'd1;
  assign w_final       = (w_nb_inc == 32'(NbExpected));
  assign w_timeout_hit = (w_timeout_inc >= 32'(TimeoutCycles));

`ifdef SIMMEM_RESP_CHECKER_BACKPRESSURE_EN
  logic [15:0] w_lfsr;

  simmem_lfsr16 #(
    .Seed    (LfsrSeed),
    .TapMask (LfsrTapMask)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (r_state_q == StRun),
    .state_o (w_lfsr)
  );

  assign w_run_ready = w_lfsr[0] | w_lfsr[1];
`else
  assign w_run_ready = 1'b1;
`endif

  // Ready depends on registered state only, never on valid/data.
  always_comb begin
    in_ready_o = 1'b0;
    unique case (r_state_q)
      StRun:   in_ready_o = w_run_ready;
      StDone:  in_ready_o = 1'b1;
      default: in_ready_o = 1'b0;
    endcase
  end

  assign done_o        = (r_state_q == StDone) | (r_state_q == StFail);
  assign passed_o      = (r_state_q == StDone);
  assign nb_received_o = r_nb_q;

  always_comb begin
    w_state_d   = r_state_q;
    w_timeout_d = r_timeout_q;
    unique case (r_state_q)
      StIdle: begin
        if (start_i) begin
          w_state_d   = StRun;
          w_timeout_d = '0;
        end
      end
      StRun: begin
        if (NbExpected == 0) begin
          w_state_d = StDone;
        end else if (w_hs) begin
          // A handshake beats a timeout landing in the same cycle.
          w_timeout_d = '0;
          if (!w_match) begin
            w_state_d = StFail;
          end else if (w_final) begin
            w_state_d = StDone;
          end
        end else begin
          w_timeout_d = w_timeout_inc;
          if (w_timeout_hit) begin
            w_state_d = StFail;
          end
        end
      end
      StDone: begin
        if (w_hs) begin
          w_state_d = StFail;
        end
      end
      StFail: begin
        w_state_d = StFail;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign w_nb_d = w_hs ? w_nb_inc : r_nb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q   <= StIdle;
      r_nb_q      <= '0;
      r_timeout_q <= '0;
    end else begin
      r_state_q   <= w_state_d;
      r_nb_q      <= w_nb_d;
      r_timeout_q <= w_timeout_d;
    end
  end

  // Each ID advances by the ID count so its low bits keep naming the ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NbIds; i++) begin
        r_exp_q[i] <= StructWidth'(i);
      end
    end else if (w_hs && w_match) begin
      r_exp_q[w_id] <= r_exp_q[w_id] + StructWidth'(NbIds);
    end
  end

endmodule
